// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
// A FIFO entry carries the scan code plus the folded prefix flags.
package ps2_pkg;

  localparam logic [7:0] PS2_BREAK      = 8'hF0;
  localparam logic [7:0] PS2_EXT        = 8'hE0;
  localparam int         PS2_FRAME_BITS = 11;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_entry_t;

  // f[0]=start, f[8:1]=data, f[9]=parity, f[10]=stop
  function automatic logic frame_ok(input logic [PS2_FRAME_BITS-1:0] f);
    return (f[0] == 1'b0) && (f[10] == 1'b1) && ((^f[9:1]) == 1'b1);
  endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// Entry FIFO with a registered head: dout holds the oldest entry and keeps
// its last value once the FIFO drains.
module ps2_byte_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       push,
  input  logic       pop,
  input  ps2_entry_t din,
  output ps2_entry_t dout,
  output logic       empty,
  output logic       full
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  ps2_entry_t  dout_q, dout_d;
  ps2_entry_t  mem_q [FIFO_DEPTH];
  logic        push_ok, pop_ok;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop_ok  = pop & ~empty;
  // A full FIFO still accepts a push when the same cycle frees a slot.
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    wptr_d = wptr_q + {{AW{1'b0}}, push_ok};
    rptr_d = rptr_q + {{AW{1'b0}}, pop_ok};
    dout_d = dout_q;
    if (rptr_d != wptr_d) begin
      // The next head may be the entry being written this very cycle.
      if (push_ok && (rptr_d == wptr_q)) begin
        dout_d = din;
      end else begin
        dout_d = mem_q[rptr_d[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wptr_q[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      dout_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: pin synchroniser, frame FSM with idle timeout,
// optional E0/F0 prefix folding, and a scan-code FIFO with read handshake.
//
//  state    | meaning
//  ST_IDLE  | waiting for the start-bit fall of ps2_clk
//  ST_DATA  | collecting bits 1..10; idle timeout armed
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 50000,
  parameter int MAKE_BREAK  = 0
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       is_break,
  output logic       is_ext,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_DATA = 1'b1;

  localparam int             TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0]  TO_LOAD  = TW'(TIMEOUT_CYC);
  localparam logic [TW-1:0]  TO_ONE   = TW'(1);
  localparam logic [3:0]     LAST_BIT = 4'(PS2_FRAME_BITS - 1);

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
  logic                   clk_prev_q, clk_prev_d;
  logic                   nd_prev_q, nd_prev_d;
  logic [0:0]             state_q, state_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [9:0]             shift_q, shift_d;
  logic [TW-1:0]          to_cnt_q, to_cnt_d;
  logic                   pend_ext_q, pend_ext_d;
  logic                   pend_brk_q, pend_brk_d;
  logic                   overflow_q, overflow_d;
  logic                   ferr_q, ferr_d;

  logic                   fall, dat_s, byte_valid;
  logic [PS2_FRAME_BITS-1:0] frame;
  logic                   push_req, pop_req;
  ps2_entry_t             push_entry, head;
  logic                   fifo_empty, fifo_full;

  assign dat_s   = dat_sync_q[SYNC_STAGES-1];
  assign fall    = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
  assign frame   = {dat_s, shift_q};
  assign pop_req = nd_prev_q & ~nextdata_n;

  always_comb begin
    clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
    dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], ps2_data};
    clk_prev_d = clk_sync_q[SYNC_STAGES-1];
    nd_prev_d  = nextdata_n;
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    to_cnt_d   = to_cnt_q;
    ferr_d     = 1'b0;
    byte_valid = 1'b0;

    if (fall) begin
      to_cnt_d = TO_LOAD;
      if (bit_cnt_q == LAST_BIT) begin
        bit_cnt_d = 4'd0;
        state_d   = ST_IDLE;
        if (frame_ok(frame)) begin
          byte_valid = 1'b1;
        end else begin
          ferr_d = 1'b1;
        end
      end else begin
        shift_d   = {dat_s, shift_q[9:1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
        state_d   = ST_DATA;
      end
    end else if (state_q == ST_DATA) begin
      // Terminal count reached: TIMEOUT_CYC cycles since the last fall.
      if (to_cnt_q == TO_ONE) begin
        ferr_d    = 1'b1;
        bit_cnt_d = 4'd0;
        state_d   = ST_IDLE;
        to_cnt_d  = TO_LOAD;
      end else begin
        to_cnt_d = to_cnt_q - TO_ONE;
      end
    end else begin
      to_cnt_d = TO_LOAD;
    end
  end

  always_comb begin
    pend_ext_d = pend_ext_q;
    pend_brk_d = pend_brk_q;
    push_req   = 1'b0;
    push_entry = '0;
    if (byte_valid) begin
      if ((MAKE_BREAK != 0) && (frame[8:1] == PS2_EXT)) begin
        pend_ext_d = 1'b1;
      end else if ((MAKE_BREAK != 0) && (frame[8:1] == PS2_BREAK)) begin
        pend_brk_d = 1'b1;
      end else begin
        push_req        = 1'b1;
        push_entry.ext  = pend_ext_q;
        push_entry.brk  = pend_brk_q;
        push_entry.code = frame[8:1];
        pend_ext_d      = 1'b0;
        pend_brk_d      = 1'b0;
      end
    end
    overflow_d = overflow_q | (push_req & fifo_full & ~pop_req);
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_prev_q <= 1'b1;
      nd_prev_q  <= 1'b1;
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 4'd0;
      shift_q    <= '0;
      to_cnt_q   <= TO_LOAD;
      pend_ext_q <= 1'b0;
      pend_brk_q <= 1'b0;
      overflow_q <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      clk_prev_q <= clk_prev_d;
      nd_prev_q  <= nd_prev_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      to_cnt_q   <= to_cnt_d;
      pend_ext_q <= pend_ext_d;
      pend_brk_q <= pend_brk_d;
      overflow_q <= overflow_d;
      ferr_q     <= ferr_d;
    end
  end

  ps2_byte_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .clrn (clrn),
    .push (push_req),
    .pop  (pop_req),
    .din  (push_entry),
    .dout (head),
    .empty(fifo_empty),
    .full (fifo_full)
  );

  assign data      = head.code;
  assign is_break  = head.brk;
  assign is_ext    = head.ext;
  assign ready     = ~fifo_empty;
  assign overflow  = overflow_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench: two receivers share the pins; dut_a is raw mode with a
// 4-deep FIFO, dut_b folds prefixes with an 8-deep FIFO.
module tb_ps2_keyboard_rx;

  localparam int HALF = 10;
  localparam int SYNC = 2;
  localparam int TOUT = 300;

  logic clk = 1'b0;
  logic clrn = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  logic nextdata_n = 1'b1;

  logic [7:0] data_a, data_b;
  logic brk_a, brk_b, ext_a, ext_b, ready_a, ready_b, ovf_a, ovf_b, ferr_a, ferr_b;

  int total = 0;
  int bad = 0;
  int ferr_a_cnt = 0;
  int ferr_b_cnt = 0;
  int f0;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ferr_a === 1'b1) ferr_a_cnt++;
    if (ferr_b === 1'b1) ferr_b_cnt++;
  end

  ps2_keyboard_rx #(.FIFO_DEPTH(4), .SYNC_STAGES(SYNC), .TIMEOUT_CYC(TOUT), .MAKE_BREAK(0)) dut_a (
    .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .nextdata_n(nextdata_n),
    .data(data_a), .is_break(brk_a), .is_ext(ext_a), .ready(ready_a),
    .overflow(ovf_a), .frame_err(ferr_a));

  ps2_keyboard_rx #(.FIFO_DEPTH(8), .SYNC_STAGES(SYNC), .TIMEOUT_CYC(TOUT), .MAKE_BREAK(1)) dut_b (
    .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .nextdata_n(nextdata_n),
    .data(data_b), .is_break(brk_b), .is_ext(ext_b), .ready(ready_b),
    .overflow(ovf_b), .frame_err(ferr_b));

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    clrn = 1'b0;
    cyc(3);
    clrn = 1'b1;
    cyc(2);
  endtask

  // Sends the first nbits of a frame; bad_par flips parity; pop_at_stop
  // lowers nextdata_n so the pop lands on the same clk edge as the push.
  task automatic ps2_send(input logic [7:0] b, input logic bad_par, input int nbits,
                          input bit pop_at_stop);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      cyc(HALF);
      ps2_clk = 1'b0;
      if (pop_at_stop && i == 10) begin
        cyc(SYNC);
        nextdata_n = 1'b0;
        cyc(1);
        nextdata_n = 1'b1;
        cyc(HALF - SYNC - 1);
      end else begin
        cyc(HALF);
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    cyc(HALF);
  endtask

  task automatic send(input logic [7:0] b);
    ps2_send(b, 1'b0, 11, 1'b0);
  endtask

  task automatic pop_n(input int n);
    nextdata_n = 1'b0;
    cyc(n);
    nextdata_n = 1'b1;
    cyc(2);
  endtask

  initial begin
    cyc(3);
    chk("rst_data", 32'(data_a), 32'h00);
    chk("rst_ready", 32'(ready_a), 32'h0);
    chk("rst_ovf", 32'(ovf_a), 32'h0);
    chk("rst_ferr", 32'(ferr_a), 32'h0);
    chk("rst_flags_b", 32'({brk_b, ext_b, ready_b}), 32'h0);
    clrn = 1'b1;
    cyc(2);

    // 1: single code, held strobe pops once
    send(8'h1C);
    chk("t1_ready", 32'(ready_a), 32'h1);
    chk("t1_data", 32'(data_a), 32'h1C);
    send(8'h32);
    pop_n(2);
    chk("t1_one_pop_data", 32'(data_a), 32'h32);
    chk("t1_one_pop_ready", 32'(ready_a), 32'h1);
    pop_n(2);
    chk("t1_empty", 32'(ready_a), 32'h0);
    chk("t1_hold", 32'(data_a), 32'h32);
    pop_n(1);
    chk("t1_pop_empty", 32'(ready_a), 32'h0);

    // 2: prefix folding
    do_reset();
    send(8'hF0);
    send(8'h1C);
    chk("t2_b_data", 32'(data_b), 32'h1C);
    chk("t2_b_flags", 32'({brk_b, ext_b}), 32'b10);
    chk("t2_a_raw", 32'({brk_a, ext_a, data_a}), 32'h0F0);
    pop_n(1);
    chk("t2_b_single", 32'(ready_b), 32'h0);
    chk("t2_a_second", 32'(data_a), 32'h1C);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    chk("t2_b_data75", 32'(data_b), 32'h75);
    chk("t2_b_flags75", 32'({brk_b, ext_b}), 32'b11);
    pop_n(1);
    chk("t2_b_empty", 32'(ready_b), 32'h0);
    send(8'hE0);
    send(8'hE0);
    send(8'h1C);
    chk("t2_ee_entry", 32'({brk_b, ext_b, data_b}), 32'h11C);

    // 3: parity error
    do_reset();
    f0 = ferr_a_cnt;
    ps2_send(8'h1B, 1'b1, 11, 1'b0);
    chk("t3_ferr", 32'(ferr_a_cnt - f0), 32'd1);
    chk("t3_no_push", 32'(ready_a), 32'h0);
    send(8'h1B);
    chk("t3_recover_ready", 32'(ready_a), 32'h1);
    chk("t3_recover_data", 32'(data_a), 32'h1B);
    chk("t3_no_extra_ferr", 32'(ferr_a_cnt - f0), 32'd1);

    // 4: overflow on 4-deep FIFO
    do_reset();
    for (int i = 0; i < 5; i++) send(8'h1B);
    chk("t4_ovf_a", 32'(ovf_a), 32'h1);
    chk("t4_ovf_b", 32'(ovf_b), 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk("t4_pop_data", 32'({ready_a, data_a}), 32'h11B);
      pop_n(1);
    end
    chk("t4_drained", 32'(ready_a), 32'h0);
    chk("t4_b_left", 32'(ready_b), 32'h1);
    chk("t4_ovf_sticky", 32'(ovf_a), 32'h1);
    do_reset();
    for (int i = 0; i < 4; i++) send(8'h1B);
    chk("t4_full_no_ovf", 32'(ovf_a), 32'h0);
    ps2_send(8'h1C, 1'b0, 11, 1'b1);
    chk("t4_pushpop_ovf", 32'(ovf_a), 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("t4_pp_data", 32'({ready_a, data_a}), 32'h11B);
      pop_n(1);
    end
    chk("t4_pp_last", 32'({ready_a, data_a}), 32'h11C);
    pop_n(1);
    chk("t4_pp_empty", 32'(ready_a), 32'h0);

    // 5: idle timeout mid-frame
    do_reset();
    f0 = ferr_a_cnt;
    ps2_send(8'h1C, 1'b0, 4, 1'b0);
    cyc(TOUT + 50);
    chk("t5_timeout_ferr", 32'(ferr_a_cnt - f0), 32'd1);
    chk("t5_no_push", 32'(ready_a), 32'h0);
    send(8'h1C);
    chk("t5_recover", 32'({ready_a, data_a}), 32'h11C);
    chk("t5_no_extra_ferr", 32'(ferr_a_cnt - f0), 32'd1);

    // 6: reset mid-frame with queued entries
    do_reset();
    for (int i = 0; i < 5; i++) send(8'h1B);
    chk("t6_pre_ovf", 32'(ovf_a), 32'h1);
    ps2_send(8'h2A, 1'b0, 5, 1'b0);
    do_reset();
    chk("t6_ready", 32'(ready_a), 32'h0);
    chk("t6_ovf", 32'(ovf_a), 32'h0);
    chk("t6_data", 32'(data_a), 32'h00);
    chk("t6_ready_b", 32'(ready_b), 32'h0);
    f0 = ferr_a_cnt;
    send(8'h1C);
    chk("t6_clean", 32'({ready_a, data_a}), 32'h11C);
    chk("t6_no_ferr", 32'(ferr_a_cnt - f0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
